// File: rtl/display_pkg.sv
// Shared seven-segment code constants and segment bit order for the display path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package display_pkg;

  // Segment bit positions within a 7-bit code: {g,f,e,d,c,b,a}.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-low codes: a 0 bit lights the segment.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Decodes one 4-bit BCD code to active-low seven-segment drive; 10..15 show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seven_seg
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 is flagged visibly as a dash.
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Snapshots nine BCD digits and scans them onto a multiplexed common-anode 7-seg display.
// Latency: a load is shown from the next visit of each slot; seg settles one cycle into a slot.
// Backpressure: none; load is accepted every cycle and simply overwrites the snapshot.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 9,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [3:0]            BCD0,
  input  logic [3:0]            BCD1,
  input  logic [3:0]            BCD2,
  input  logic [3:0]            BCD3,
  input  logic [3:0]            BCD4,
  input  logic [3:0]            BCD5,
  input  logic [3:0]            BCD6,
  input  logic [3:0]            BCD7,
  input  logic [3:0]            BCD8,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic [3:0]            slot_idx,
  output logic                  frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // The converter always supplies nine digits; NUM_DIGITS is expected to stay at or below that.
  logic [3:0] bcd_all [9];
  assign bcd_all[0] = BCD0;
  assign bcd_all[1] = BCD1;
  assign bcd_all[2] = BCD2;
  assign bcd_all[3] = BCD3;
  assign bcd_all[4] = BCD4;
  assign bcd_all[5] = BCD5;
  assign bcd_all[6] = BCD6;
  assign bcd_all[7] = BCD7;
  assign bcd_all[8] = BCD8;

  logic [PW-1:0]         prescaler;
  logic [PW-1:0]         pres_nxt;
  logic [3:0]            slot_nxt;
  logic                  terminal;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [3:0]            snapshot [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            dec_seg;

  // A digit is a leading zero when it and every more significant digit are zero;
  // invalid codes count as nonzero, and position 0 always shows.
  always_comb begin
    logic nz_above;
    nz_above   = 1'b0;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_above      = nz_above | (snapshot[i] != 4'd0);
      blank_mask[i] = (BLANK_LEADING != 0) && (i != 0) && !nz_above;
    end
  end

  // Select the digit for the current slot; an out-of-range slot falls back to blank zero.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_idx == 4'(i)) begin
        cur_digit = snapshot[i];
        cur_blank = blank_mask[i];
      end
    end
  end

  bcd_to_seven_seg u_dec (
    .code (cur_digit),
    .seg  (dec_seg)
  );

  // Prescaler/slot advance and the anode pattern for the cycle being entered, so an
  // lines up with the registered prescaler value (dark while prescaler < BLANK_CYCLES).
  always_comb begin
    terminal = (prescaler == PW'(SCAN_DIV - 1));
    pres_nxt = terminal ? '0 : prescaler + PW'(1);
    slot_nxt = slot_idx;
    if (terminal) begin
      slot_nxt = (slot_idx == 4'(NUM_DIGITS - 1)) ? 4'd0 : slot_idx + 4'd1;
    end
    if (int'(pres_nxt) < BLANK_CYCLES) begin
      an_nxt = '1;
    end else begin
      an_nxt = ~(NUM_DIGITS'(1) << slot_nxt);
    end
  end

  assign frame_done = terminal && (slot_idx == 4'(NUM_DIGITS - 1));

  // Scan state, snapshot and output registers; seg is only re-sampled in the first
  // cycle of a slot, so a load mid-slot never disturbs the digit being shown.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prescaler <= '0;
      slot_idx  <= 4'd0;
      an        <= '1;
      seg       <= SEG_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snapshot[i] <= 4'd0;
      end
    end else begin
      prescaler <= pres_nxt;
      slot_idx  <= slot_nxt;
      an        <= an_nxt;
      if (prescaler == '0) begin
        seg <= cur_blank ? SEG_OFF : dec_seg;
      end
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          snapshot[i] <= bcd_all[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: two scanners (leading-zero blanking on and off) against a frame-position model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_display_scanner;

  localparam int ND   = 9;
  localparam int DIV  = 4;
  localparam int BLK  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] bcd [9];

  logic [8:0] an1, an0;
  logic [6:0] seg1, seg0;
  logic [3:0] slot1, slot0;
  logic       fd1, fd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .BLANK_LEADING(1)) u_dut (
    .Clk(clk), .Reset(rst), .load(load),
    .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]), .BCD4(bcd[4]),
    .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]), .BCD8(bcd[8]),
    .an(an1), .seg(seg1), .slot_idx(slot1), .frame_done(fd1)
  );

  bcd_display_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .BLANK_LEADING(0)) u_dut_nb (
    .Clk(clk), .Reset(rst), .load(load),
    .BCD0(bcd[0]), .BCD1(bcd[1]), .BCD2(bcd[2]), .BCD3(bcd[3]), .BCD4(bcd[4]),
    .BCD5(bcd[5]), .BCD6(bcd[6]), .BCD7(bcd[7]), .BCD8(bcd[8]),
    .an(an0), .seg(seg0), .slot_idx(slot0), .frame_done(fd0)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // t = cycles since the first cycle with Reset low; everything follows from t.
  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  int         t      = 0;
  bit         mvalid = 0;
  logic [3:0] msnap [9];
  logic [6:0] mseg1, mseg0;

  function automatic logic [6:0] disp(input bit bl, input int i);
    bit nz = 0;
    for (int j = i; j < 9; j++) if (msnap[j] != 4'd0) nz = 1;
    if (bl && i > 0 && !nz) return 7'h7f;
    return segtab[msnap[i]];
  endfunction

  always @(negedge clk) begin
    int         es, ep;
    logic [8:0] ea;
    logic       efd;
    if (mvalid) begin
      es  = (t / DIV) % ND;
      ep  = t % DIV;
      ea  = (ep < BLK) ? 9'h1ff : ~(9'd1 << es);
      efd = (es == ND - 1) && (ep == DIV - 1);
      chk("cyc_an",      an1,   ea);
      chk("cyc_seg",     seg1,  mseg1);
      chk("cyc_slot",    slot1, es);
      chk("cyc_fd",      fd1,   efd);
      chk("cyc_an_nb",   an0,   ea);
      chk("cyc_seg_nb",  seg0,  mseg0);
      chk("cyc_slot_nb", slot0, es);
      chk("cyc_fd_nb",   fd0,   efd);
    end
    if (rst) begin
      t = 0;
      for (int i = 0; i < 9; i++) msnap[i] = 4'd0;
      mseg1  = 7'h7f;
      mseg0  = 7'h7f;
      mvalid = 1;
    end else if (mvalid) begin
      if (t % DIV == 0) begin
        mseg1 = disp(1'b1, (t / DIV) % ND);
        mseg0 = disp(1'b0, (t / DIV) % ND);
      end
      if (load) for (int i = 0; i < 9; i++) msnap[i] = bcd[i];
      t++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_bcd(input logic [35:0] v);
    for (int i = 0; i < 9; i++) bcd[i] = v[4*i +: 4];
  endtask

  task automatic do_load(input logic [35:0] v);
    @(posedge clk); #1;
    set_bcd(v);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  // Returns at posedge+2 of the cycle the model places at slot s, prescaler p.
  task automatic wait_pos(input int s, input int p);
    bit found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #2;
      if ((t / DIV) % ND == s && t % DIV == p) found = 1;
    end
    if (!found) chk("wait_pos_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int an0_low, fdc;
    rst  = 1'b1;
    load = 1'b0;
    set_bcd(36'h0);

    @(posedge clk); @(posedge clk); #2;
    chk("rst_an",   an1,   9'h1ff);
    chk("rst_seg",  seg1,  7'h7f);
    chk("rst_slot", slot1, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    an0_low = 0;
    fdc     = 0;
    for (int k = 0; k < 72; k++) begin
      if (k < 4 && an1[0] == 1'b0) an0_low++;
      if (fd1) fdc++;
      @(posedge clk); #2;
    end
    chk("an0_low_cycles", an0_low, 3);
    chk("frame_done_2frames", fdc, 2);

    do_load(36'h650345768);
    wait_pos(0, 2); chk("l1_slot0", seg1, 7'b0000000);
    wait_pos(2, 2); chk("l1_slot2", seg1, 7'b1111000);
    wait_pos(6, 2); chk("l1_slot6", seg1, 7'b1000000);
    wait_pos(8, 2); chk("l1_slot8", seg1, 7'b0000010);

    wait_pos(4, 2);
    bcd[4] = 4'd9;
    load   = 1'b1;
    @(posedge clk); #1;
    load   = 1'b0;
    chk("midload_hold", seg1, 7'b0011001);
    wait_pos(4, 1); chk("midload_new", seg1, 7'b0010000);

    do_load(36'h001234593);
    wait_pos(6, 2); chk("l2_slot6", seg1, 7'b1111001);
    wait_pos(7, 2);
    chk("l2_slot7_an",  an1,  9'h17f);
    chk("l2_slot7_seg", seg1, 7'h7f);
    chk("l2_slot7_nb",  seg0, 7'b1000000);
    wait_pos(8, 2);
    chk("l2_slot8_an",  an1,  9'h0ff);
    chk("l2_slot8_seg", seg1, 7'h7f);
    chk("l2_slot8_nb",  seg0, 7'b1000000);

    do_load(36'h000000000);
    wait_pos(0, 2); chk("zero_slot0", seg1, 7'b1000000);
    wait_pos(1, 2); chk("zero_slot1", seg1, 7'h7f);
    wait_pos(5, 2); chk("zero_slot5", seg1, 7'h7f);

    do_load(36'h00000C000);
    wait_pos(1, 2); chk("dash_slot1", seg1, 7'b1000000);
    wait_pos(2, 2); chk("dash_slot2", seg1, 7'b1000000);
    wait_pos(3, 2); chk("dash_slot3", seg1, 7'b0111111);
    wait_pos(4, 2); chk("dash_slot4", seg1, 7'h7f);

    do_load(36'h650345768);
    wait_pos(5, 1);
    rst  = 1'b1;
    load = 1'b1;
    set_bcd(36'h999999999);
    @(posedge clk); #1;
    chk("midrst_an",   an1,   9'h1ff);
    chk("midrst_seg",  seg1,  7'h7f);
    chk("midrst_slot", slot1, 4'd0);
    rst  = 1'b0;
    load = 1'b0;
    repeat (40) @(posedge clk);
    wait_pos(3, 2);
    chk("postrst_slot3_seg", seg1, 7'h7f);
    chk("postrst_slot3_an",  an1,  9'h1f7);
    wait_pos(0, 2);
    chk("postrst_slot0_seg", seg1, 7'b1000000);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
